// File: rtl/baud_generator_frac_pkg.sv
// Shared constants for the fractional UART baud generator: the rate table,
// the select codes and the elaboration-time divisor calculation.
package baud_pkg;

  localparam int unsigned NUM_RATES = 32'd9;

  localparam int unsigned BAUD_TABLE [NUM_RATES] = '{
    32'd1200, 32'd2400, 32'd4800, 32'd9600, 32'd19200,
    32'd38400, 32'd57600, 32'd115200, 32'd230400
  };

  localparam int unsigned DEFAULT_SEL = 32'd3;
  localparam int unsigned CUSTOM_SEL  = 32'd15;

  // Rounded clk cycles per oversample tick in 1/2^frac_w units, i.e. {int, frac}
  function automatic longint unsigned calc_div(input longint unsigned clk_hz,
                                               input longint unsigned baud,
                                               input longint unsigned osr,
                                               input int unsigned     frac_w);
    longint unsigned denom;
    denom = baud * osr;
    return ((clk_hz << frac_w) + (denom / 64'd2)) / denom;
  endfunction

endpackage

// File: rtl/baud_generator_frac_if.sv
// Configuration and tick bundle between a UART channel and its baud generator.
interface baud_generator_frac_if #(
  parameter int unsigned DIV_INT_W = 32'd16,
  parameter int unsigned FRAC_W    = 32'd4,
  parameter int unsigned OSR       = 32'd16
);
  localparam int unsigned PHASE_W = $clog2(OSR);

  logic                 enable;
  logic [3:0]           baud_rate_sel;
  logic [DIV_INT_W-1:0] cfg_div_int;
  logic [FRAC_W-1:0]    cfg_div_frac;
  logic                 rx_resync;
  logic                 os_tick;
  logic                 sample_tick;
  logic                 bit_tick;
  logic [PHASE_W-1:0]   os_phase;
  logic                 cfg_pending;
  logic                 cfg_err;

  modport master (
    output enable, baud_rate_sel, cfg_div_int, cfg_div_frac, rx_resync,
    input  os_tick, sample_tick, bit_tick, os_phase, cfg_pending, cfg_err
  );

  modport slave (
    input  enable, baud_rate_sel, cfg_div_int, cfg_div_frac, rx_resync,
    output os_tick, sample_tick, bit_tick, os_phase, cfg_pending, cfg_err
  );

endinterface

// File: rtl/baud_generator_frac_nco.sv
// Fractional-N cycle divider: period alternates between div_int and div_int+1
// so the average period is div_int + div_frac/2^FRAC_W with no drift.
module baud_frac_nco #(
  parameter int unsigned DIV_INT_W = 32'd16,
  parameter int unsigned FRAC_W    = 32'd4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear_i,
  input  logic [DIV_INT_W-1:0] div_int_i,
  input  logic [FRAC_W-1:0]    div_frac_i,
  output logic                 tick_o
);

  logic [DIV_INT_W-1:0] cnt_q, cnt_d;
  logic [FRAC_W-1:0]    acc_q, acc_d;
  logic [FRAC_W:0]      sum_s;
  logic [DIV_INT_W:0]   period_m1_s;
  logic                 hit_s;

  assign sum_s       = {1'b0, acc_q} + {1'b0, div_frac_i};
  assign period_m1_s = {1'b0, div_int_i} + {{DIV_INT_W{1'b0}}, sum_s[FRAC_W]}
                       - {{DIV_INT_W{1'b0}}, 1'b1};
  assign hit_s       = ({1'b0, cnt_q} == period_m1_s);
  assign tick_o      = hit_s & ~clear_i;

  // Next-state for cycle counter and fractional accumulator
  always_comb begin
    cnt_d = cnt_q + {{(DIV_INT_W-1){1'b0}}, 1'b1};
    acc_d = acc_q;
    if (clear_i) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (hit_s) begin
      cnt_d = '0;
      acc_d = sum_s[FRAC_W-1:0];
    end else begin
      acc_d = acc_q;
    end
  end

  // Counter and accumulator state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/baud_generator_frac.sv
// UART baud generator: selects a divisor, holds it stable across each bit and
// derives oversample, mid-bit sample and end-of-bit ticks from a fractional NCO.
module baud_generator_frac
  import baud_pkg::*;
#(
  parameter longint unsigned CLK_FREQ_HZ = 64'd100_000_000,
  parameter int unsigned     OSR         = 32'd16,
  parameter int unsigned     DIV_INT_W   = 32'd16,
  parameter int unsigned     FRAC_W      = 32'd4
) (
  input  logic               clk,
  input  logic               reset_n,
  baud_generator_frac_if.slave bus
);

  localparam int unsigned PHASE_W = $clog2(OSR);
  localparam int unsigned DW      = DIV_INT_W + FRAC_W;
  localparam logic [DW-1:0] DEF_DIV =
    DW'(calc_div(CLK_FREQ_HZ, 64'(BAUD_TABLE[DEFAULT_SEL]), 64'(OSR), FRAC_W));

  logic [DW-1:0]      rate_div_s [NUM_RATES];
  logic [DW-1:0]      req_div_d, req_div_q, act_div_q;
  logic               cfg_err_d, cfg_err_q;
  logic [PHASE_W-1:0] phase_q;
  logic               clear_s, os_tick_s, bit_tick_s, sample_tick_s, load_s;

  for (genvar g = 0; g < NUM_RATES; g++) begin : g_rate
    localparam logic [DW-1:0] RATE_DIV =
      DW'(calc_div(CLK_FREQ_HZ, 64'(BAUD_TABLE[g]), 64'(OSR), FRAC_W));
    assign rate_div_s[g] = RATE_DIV;
  end

  // Requested divisor from select/custom inputs; reserved codes fall back to 9600
  always_comb begin
    req_div_d = DEF_DIV;
    cfg_err_d = 1'b0;
    if (bus.baud_rate_sel == 4'(CUSTOM_SEL)) begin
      if (bus.cfg_div_int < DIV_INT_W'(2)) begin
        req_div_d = {DIV_INT_W'(2), bus.cfg_div_frac};
        cfg_err_d = 1'b1;
      end else begin
        req_div_d = {bus.cfg_div_int, bus.cfg_div_frac};
      end
    end else if (bus.baud_rate_sel < 4'(NUM_RATES)) begin
      req_div_d = rate_div_s[bus.baud_rate_sel];
    end else begin
      cfg_err_d = 1'b1;
    end
  end

  assign clear_s = ~bus.enable | bus.rx_resync;

  baud_frac_nco #(
    .DIV_INT_W (DIV_INT_W),
    .FRAC_W    (FRAC_W)
  ) u_nco (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_i    (clear_s),
    .div_int_i  (act_div_q[DW-1:FRAC_W]),
    .div_frac_i (act_div_q[FRAC_W-1:0]),
    .tick_o     (os_tick_s)
  );

  assign bit_tick_s    = os_tick_s & (phase_q == PHASE_W'(OSR - 32'd1));
  assign sample_tick_s = os_tick_s & (phase_q == PHASE_W'((OSR / 32'd2) - 32'd1));
  // The active divisor only moves at a bit boundary or while the phase is being cleared
  assign load_s        = clear_s | bit_tick_s;

  // Shadow/active divisor, error flag and oversample phase
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_div_q <= DEF_DIV;
      act_div_q <= DEF_DIV;
      cfg_err_q <= 1'b0;
      phase_q   <= '0;
    end else begin
      req_div_q <= req_div_d;
      cfg_err_q <= cfg_err_d;
      if (load_s) begin
        act_div_q <= req_div_q;
      end else begin
        act_div_q <= act_div_q;
      end
      if (clear_s) begin
        phase_q <= '0;
      end else if (os_tick_s) begin
        phase_q <= phase_q + PHASE_W'(1);
      end else begin
        phase_q <= phase_q;
      end
    end
  end

  assign bus.os_tick     = os_tick_s;
  assign bus.sample_tick = sample_tick_s;
  assign bus.bit_tick    = bit_tick_s;
  assign bus.os_phase    = phase_q;
  assign bus.cfg_pending = (req_div_q != act_div_q);
  assign bus.cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_baud_generator_frac.sv
// Directed bench for baud_generator_frac at the default 100 MHz / OSR 16 / 4-bit fraction.
module tb_baud_generator_frac;

  logic clk = 1'b0;
  logic reset_n;
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  baud_generator_frac_if bus ();

  baud_generator_frac dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Count negedges until os_tick is seen (bounded)
  task automatic wait_os(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.os_tick !== 1'b1 && n < 20000);
  endtask

  task automatic wait_bit(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.bit_tick !== 1'b1 && n < 20000);
  endtask

  task automatic pulse_resync();
    @(posedge clk);
    #1 bus.rx_resync = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 bus.rx_resync = 1'b0;
  endtask

  task automatic test_reset();
    reset_n           = 1'b1;
    bus.enable        = 1'b0;
    bus.baud_rate_sel = 4'd8;
    bus.cfg_div_int   = 16'd0;
    bus.cfg_div_frac  = 4'd0;
    bus.rx_resync     = 1'b0;
    #1 reset_n = 1'b0;
    #10;
    cmp_cnt++;
    if ({bus.os_tick, bus.sample_tick, bus.bit_tick} !== 3'b000) begin
      err_cnt++;
      $display("FAIL reset_ticks: got %b want 000", {bus.os_tick, bus.sample_tick, bus.bit_tick});
    end
    cmp_cnt++;
    if (bus.os_phase !== 4'd0) begin
      err_cnt++;
      $display("FAIL reset_phase: got %0d want 0", bus.os_phase);
    end
    cmp_cnt++;
    if ({bus.cfg_pending, bus.cfg_err} !== 2'b00) begin
      err_cnt++;
      $display("FAIL reset_cfg: got %b want 00", {bus.cfg_pending, bus.cfg_err});
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    cmp_cnt++;
    if ({bus.cfg_pending, bus.cfg_err} !== 2'b00) begin
      err_cnt++;
      $display("FAIL idle_cfg_sel8: got %b want 00", {bus.cfg_pending, bus.cfg_err});
    end
  endtask

  task automatic test_rate_sel8();
    int n;
    int exp_n;
    @(posedge clk);
    #1 bus.enable = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wait_os(n);
      exp_n = ((i % 8) == 0) ? 28 : 27;
      cmp_cnt++;
      if (n !== exp_n) begin
        err_cnt++;
        $display("FAIL sel8_interval[%0d]: got %0d want %0d", i, n, exp_n);
      end
      cmp_cnt++;
      if (bus.sample_tick !== (i == 8)) begin
        err_cnt++;
        $display("FAIL sel8_sample[%0d]: got %b want %b", i, bus.sample_tick, (i == 8));
      end
      cmp_cnt++;
      if (bus.bit_tick !== (i == 16)) begin
        err_cnt++;
        $display("FAIL sel8_bit[%0d]: got %b want %b", i, bus.bit_tick, (i == 16));
      end
    end
    wait_bit(n);
    cmp_cnt++;
    if (n !== 434) begin
      err_cnt++;
      $display("FAIL sel8_bit_period: got %0d want 434", n);
    end
  endtask

  task automatic test_switch();
    int n;
    int m;
    int p;
    n = 0;
    repeat (100) begin
      @(negedge clk);
      n++;
    end
    bus.baud_rate_sel = 4'd3;
    repeat (2) begin
      @(negedge clk);
      n++;
    end
    cmp_cnt++;
    if (bus.cfg_pending !== 1'b1) begin
      err_cnt++;
      $display("FAIL switch_pending_set: got %b want 1", bus.cfg_pending);
    end
    wait_bit(m);
    cmp_cnt++;
    if (n + m !== 434) begin
      err_cnt++;
      $display("FAIL switch_bit_complete: got %0d want 434", n + m);
    end
    wait_os(p);
    cmp_cnt++;
    if (p !== 651) begin
      err_cnt++;
      $display("FAIL switch_new_interval: got %0d want 651", p);
    end
    cmp_cnt++;
    if (bus.cfg_pending !== 1'b0) begin
      err_cnt++;
      $display("FAIL switch_pending_clr: got %b want 0", bus.cfg_pending);
    end
  endtask

  task automatic test_sel7_drift();
    int n;
    int total;
    bus.baud_rate_sel = 4'd7;
    repeat (2) @(negedge clk);
    pulse_resync();
    total = 0;
    for (int i = 0; i < 16; i++) begin
      wait_bit(n);
      total += n;
      cmp_cnt++;
      if (n !== 868) begin
        err_cnt++;
        $display("FAIL sel7_bit[%0d]: got %0d want 868", i, n);
      end
    end
    cmp_cnt++;
    if (total !== 13888) begin
      err_cnt++;
      $display("FAIL sel7_total: got %0d want 13888", total);
    end
  endtask

  task automatic test_resync();
    int n;
    // After a bit boundary at 54/4 the next os_tick is due exactly 54 cycles on
    wait_bit(n);
    bus.baud_rate_sel = 4'd8;
    repeat (54) @(posedge clk);
    #1 bus.rx_resync = 1'b1;
    @(negedge clk);
    cmp_cnt++;
    if ({bus.os_tick, bus.sample_tick, bus.bit_tick} !== 3'b000) begin
      err_cnt++;
      $display("FAIL resync_ticks: got %b want 000", {bus.os_tick, bus.sample_tick, bus.bit_tick});
    end
    @(posedge clk);
    #1 bus.rx_resync = 1'b0;
    cmp_cnt++;
    if (bus.os_phase !== 4'd0) begin
      err_cnt++;
      $display("FAIL resync_phase: got %0d want 0", bus.os_phase);
    end
    for (int i = 1; i <= 8; i++) begin
      wait_os(n);
      if (i == 1) begin
        cmp_cnt++;
        if (n !== 27) begin
          err_cnt++;
          $display("FAIL resync_first_os: got %0d want 27", n);
        end
      end
      cmp_cnt++;
      if (bus.sample_tick !== (i == 8)) begin
        err_cnt++;
        $display("FAIL resync_sample[%0d]: got %b want %b", i, bus.sample_tick, (i == 8));
      end
    end
  endtask

  task automatic test_cfg_err();
    int n;
    bus.baud_rate_sel = 4'd15;
    bus.cfg_div_int   = 16'd1;
    bus.cfg_div_frac  = 4'd0;
    repeat (2) @(negedge clk);
    cmp_cnt++;
    if (bus.cfg_err !== 1'b1) begin
      err_cnt++;
      $display("FAIL custom_low_err: got %b want 1", bus.cfg_err);
    end
    pulse_resync();
    for (int i = 0; i < 2; i++) begin
      wait_os(n);
      cmp_cnt++;
      if (n !== 2) begin
        err_cnt++;
        $display("FAIL custom_clamp_period[%0d]: got %0d want 2", i, n);
      end
    end
    bus.cfg_div_int  = 16'd5;
    bus.cfg_div_frac = 4'd3;
    repeat (2) @(negedge clk);
    cmp_cnt++;
    if (bus.cfg_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL custom_ok_err: got %b want 0", bus.cfg_err);
    end
    bus.baud_rate_sel = 4'd12;
    repeat (2) @(negedge clk);
    cmp_cnt++;
    if (bus.cfg_err !== 1'b1) begin
      err_cnt++;
      $display("FAIL reserved_err: got %b want 1", bus.cfg_err);
    end
    pulse_resync();
    wait_os(n);
    cmp_cnt++;
    if (n !== 651) begin
      err_cnt++;
      $display("FAIL reserved_period: got %0d want 651", n);
    end
  endtask

  task automatic test_enable_drop();
    int n;
    bus.baud_rate_sel = 4'd8;
    repeat (3) wait_os(n);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 bus.enable = 1'b0;
    @(negedge clk);
    cmp_cnt++;
    if ({bus.os_tick, bus.sample_tick, bus.bit_tick} !== 3'b000) begin
      err_cnt++;
      $display("FAIL endrop_ticks: got %b want 000", {bus.os_tick, bus.sample_tick, bus.bit_tick});
    end
    @(posedge clk);
    #1;
    cmp_cnt++;
    if (bus.os_phase !== 4'd0) begin
      err_cnt++;
      $display("FAIL endrop_phase: got %0d want 0", bus.os_phase);
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 bus.enable = 1'b1;
    wait_os(n);
    cmp_cnt++;
    if (n !== 27) begin
      err_cnt++;
      $display("FAIL endrop_first_os: got %0d want 27", n);
    end
  endtask

  task automatic test_async_reset();
    int n;
    repeat (5) wait_os(n);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    cmp_cnt++;
    if (bus.os_phase !== 4'd0) begin
      err_cnt++;
      $display("FAIL arst_phase: got %0d want 0", bus.os_phase);
    end
    cmp_cnt++;
    if ({bus.os_tick, bus.sample_tick, bus.bit_tick, bus.cfg_pending, bus.cfg_err} !== 5'b00000) begin
      err_cnt++;
      $display("FAIL arst_outputs: got %b want 00000",
               {bus.os_tick, bus.sample_tick, bus.bit_tick, bus.cfg_pending, bus.cfg_err});
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    wait_os(n);
    cmp_cnt++;
    if (n !== 651) begin
      err_cnt++;
      $display("FAIL arst_first_os: got %0d want 651", n);
    end
  endtask

  initial begin
    test_reset();
    test_rate_sel8();
    test_switch();
    test_sel7_drift();
    test_resync();
    test_cfg_err();
    test_enable_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/baud_generator_frac.md
Name: baud_generator_frac

Overview:
Parametrised successor to the fixed-table UART baud generator. A fractional-N divider produces an oversample tick (os_tick), a mid-bit sample tick and a bit tick, so rates that are not integer divisions of the clock carry no accumulated drift. Rate comes from a 4-bit selection table or a runtime custom divisor. Rate changes take effect only at bit boundaries. One instance serves the TX and RX datapaths of one UART channel.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency used to build the rate table
OSR, 16, oversample ticks per bit; power of two, 4..32
DIV_INT_W, 16, width of the integer divisor
FRAC_W, 4, width of the fractional divisor and accumulator

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  run divider; low clears counters and phase
baud_rate_sel  in  4  0..8 = 1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200, 230400; 9..14 reserved; 15 = custom
cfg_div_int  in  DIV_INT_W  custom integer divisor (clk cycles per os_tick)
cfg_div_frac  in  FRAC_W  custom fractional divisor, in 1/2^FRAC_W units
rx_resync  in  1  realign phase on an RX start-bit edge
os_tick  out  1  one-cycle oversample pulse
sample_tick  out  1  one-cycle pulse at mid-bit
bit_tick  out  1  one-cycle pulse at end of bit
os_phase  out  log2(OSR)  current oversample index
cfg_pending  out  1  requested divisor differs from active divisor
cfg_err  out  1  reserved select, or custom div_int < 2

Behaviour:
- Reset: all outputs 0; counters, accumulator and phase 0; active divisor = table entry 3 (9600).
- Divisor D = round(CLK_FREQ_HZ*2^FRAC_W/(baud*OSR)), split into int and frac, computed at elaboration. At the defaults: 115200 -> 54/4, 9600 -> 651/1, 230400 -> 27/2.
- Select 9..14 uses the 9600 divisor and sets cfg_err. Custom div_int < 2 is clamped to 2 and sets cfg_err. cfg_err is registered and tracks the current inputs.
- Cycle counter cnt runs 0..P-1 with P = div_int + carry, where carry = (acc + div_frac >= 2^FRAC_W).
- os_tick is asserted in the cycle cnt == P-1. In that same cycle: cnt -> 0, acc -> (acc + div_frac) mod 2^FRAC_W, os_phase increments mod OSR.
- bit_tick = os_tick AND os_phase == OSR-1 (coincident with the phase wrap).
- sample_tick = os_tick AND os_phase == OSR/2-1.
- First os_tick arrives div_int enabled cycles after enable rises or reset releases (acc = 0).
- Requested divisor is registered from the inputs every cycle. cfg_pending = requested != active.
- The active divisor is loaded from requested only on: a bit_tick cycle (used from the next period), enable low, or rx_resync. It never changes mid-bit.
- rx_resync (synchronous, priority over tick generation):
  - clears cnt, acc and os_phase, and loads the divisor;
  - os_tick, sample_tick and bit_tick are forced 0 in that cycle;
  - the next os_tick comes div_int cycles later; the first sample_tick comes on the (OSR/2)-th os_tick after resync.
- enable low: same clearing as rx_resync, with all tick outputs held 0. A simultaneous rx_resync has no further effect.
- Asynchronous reset mid-bit returns to the reset state immediately. No tick is emitted during reset.

Decomposition:
- Package baud_pkg holds:
  - the rate table as a constant array of baud values;
  - a constant function computing {int, frac} from CLK_FREQ_HZ, OSR and FRAC_W;
  - localparams DEFAULT_SEL = 3 and CUSTOM_SEL = 15.
- One sub-module, baud_frac_nco: cnt/acc/carry logic producing a raw tick, with clear and load inputs. The top level adds the phase counter, tick decode, shadow divisor and error logic.

Test Plan:
- Reset release, enable = 1, sel = 8 (27/2): os_tick intervals are 27 cycles ×7 then 28 ×1, repeating; bit_tick every 434 cycles; sample_tick 8 os_ticks after start; cfg_err = 0.
- sel = 7 (54/4): 16 consecutive bit periods each exactly 868 cycles; zero cumulative drift over 1000 bits.
- Switch sel 8 -> 3 mid-bit: cfg_pending = 1 until the next bit_tick; the current bit completes at 434 cycles; the following os_tick interval is 651 cycles; then cfg_pending = 0.
- Assert rx_resync at an arbitrary cnt with sel = 8: no tick that cycle; os_phase = 0; os_tick 27 cycles later; sample_tick on the 8th os_tick after resync.
- sel = 15 with div_int = 1, frac = 0: cfg_err = 1 and os_tick period is 2. sel = 12: cfg_err = 1 and the 9600 divisor is used.
- Drop reset_n, then separately enable, mid-bit: all outputs 0 immediately or next cycle respectively; after release the first os_tick comes div_int cycles later.
